program_mem_controller: RTL and testbench

PROGRAM_MEM_CONTROLLER -- requirements
Module: program_mem_controller

---
 rtl/program_mem_controller_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/program_mem_controller.sv | 108 ++++++++++
 tb/tb_program_mem_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_mem_controller_pkg.sv
// Shared definitions for the program memory controller: FSM encoding and default widths.
package program_mem_controller_pkg;

  localparam int unsigned DefaultNumConsumers = 4;
  localparam int unsigned DefaultAddrBits     = 8;
  localparam int unsigned DefaultDataBits     = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StIssue   = 2'b01,
    StRespond = 2'b10,
    StRelease = 2'b11
  } pmc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_granted.
module rr_arbiter #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned IDX_BITS      = 2
) (
  input  logic [NUM_CONSUMERS-1:0] request,
  input  logic [IDX_BITS-1:0]      last_granted,
  output logic [IDX_BITS-1:0]      grant_index,
  output logic                     grant_valid
);

  // Scan offsets 1..N from the last grant so the previous winner is checked last.
  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_index = '0;
    idx         = 0;
    for (int unsigned off = 1; off <= NUM_CONSUMERS; off++) begin
      idx = (32'(last_granted) + off) % NUM_CONSUMERS;
      if (!grant_valid && request[IDX_BITS'(idx)]) begin
        grant_valid = 1'b1;
        grant_index = IDX_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/program_mem_controller.sv
// Program memory controller: serialises instruction fetches from several consumers onto a
// single program memory port, one outstanding request at a time, round-robin fair.
module program_mem_controller
  import program_mem_controller_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = DefaultNumConsumers,
  parameter int unsigned ADDR_BITS     = DefaultAddrBits,
  parameter int unsigned DATA_BITS     = DefaultDataBits
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  localparam int unsigned IdxBits = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  pmc_state_e                       state_q, state_d;
  logic [IdxBits-1:0]               grant_q, grant_d;
  logic [IdxBits-1:0]               last_q, last_d;
  logic                             mem_read_valid_d;
  logic [ADDR_BITS-1:0]             mem_read_address_d;
  logic [NUM_CONSUMERS-1:0]         consumer_read_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_d;

  logic [IdxBits-1:0]               arb_index;
  logic                             arb_valid;

  rr_arbiter #(
    .NUM_CONSUMERS (NUM_CONSUMERS),
    .IDX_BITS      (IdxBits)
  ) u_rr_arbiter (
    .request      (consumer_read_valid),
    .last_granted (last_q),
    .grant_index  (arb_index),
    .grant_valid  (arb_valid)
  );

  // Next-state and registered-output logic; the ready pulse defaults low every cycle.
  always_comb begin
    state_d               = state_q;
    grant_d               = grant_q;
    last_d                = last_q;
    mem_read_valid_d      = mem_read_valid;
    mem_read_address_d    = mem_read_address;
    consumer_read_ready_d = '0;
    consumer_read_data_d  = consumer_read_data;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d            = arb_index;
          last_d             = arb_index;
          mem_read_valid_d   = 1'b1;
          mem_read_address_d = consumer_read_address[32'(arb_index)*ADDR_BITS +: ADDR_BITS];
          state_d            = StIssue;
        end
      end
      StIssue: begin
        if (mem_read_ready) begin
          consumer_read_data_d[32'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_d[grant_q] = 1'b1;
          mem_read_valid_d               = 1'b0;
          state_d                        = StRespond;
        end
      end
      StRespond: begin
        state_d = StRelease;
      end
      StRelease: begin
        // Hold off until the served consumer withdraws, so its request is not served twice.
        if (!consumer_read_valid[grant_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= StIdle;
      grant_q             <= '0;
      last_q              <= IdxBits'(NUM_CONSUMERS - 1);
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      state_q             <= state_d;
      grant_q             <= grant_d;
      last_q              <= last_d;
      mem_read_valid      <= mem_read_valid_d;
      mem_read_address    <= mem_read_address_d;
      consumer_read_ready <= consumer_read_ready_d;
      consumer_read_data  <= consumer_read_data_d;
    end
  end

endmodule

// File: tb/tb_program_mem_controller.sv
// Directed bench for program_mem_controller with a small protocol monitor.
module tb_program_mem_controller;

  localparam int unsigned N = 4;
  localparam int unsigned A = 8;
  localparam int unsigned D = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   crv;
  logic [N*A-1:0] cra;
  logic [N-1:0]   crr;
  logic [N*D-1:0] crd;
  logic           mrv;
  logic [A-1:0]   mra;
  logic           mready;
  logic [D-1:0]   mdata;
  logic [D-1:0]   mdata_drv;
  logic           mem_auto;

  int checks = 0;
  int errors = 0;

  // Zero-wait memory model returns {8'hC0, address}; otherwise a directed word.
  assign mdata = mem_auto ? {8'hC0, mra} : mdata_drv;

  always #5 clk = ~clk;

  program_mem_controller #(
    .NUM_CONSUMERS (N),
    .ADDR_BITS     (A),
    .DATA_BITS     (D)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (crv),
    .consumer_read_address (cra),
    .consumer_read_ready   (crr),
    .consumer_read_data    (crd),
    .mem_read_valid        (mrv),
    .mem_read_address      (mra),
    .mem_read_ready        (mready),
    .mem_read_data         (mdata)
  );

  // Protocol monitor: address stable while stalled, ready one-hot and never back-to-back.
  logic         prev_mrv    = 1'b0;
  logic         prev_mready = 1'b0;
  logic [A-1:0] prev_addr   = '0;
  logic [N-1:0] prev_crr    = '0;
  logic         addr_viol   = 1'b0;
  logic         onehot_viol = 1'b0;
  logic         consec_viol = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_mrv <= 1'b0;
      prev_crr <= '0;
    end else begin
      if (prev_mrv && !prev_mready && mrv && (mra !== prev_addr)) addr_viol <= 1'b1;
      if ($countones(crr) > 1) onehot_viol <= 1'b1;
      if ((prev_crr != '0) && (crr != '0)) consec_viol <= 1'b1;
      prev_mrv    <= mrv;
      prev_mready <= mready;
      prev_addr   <= mra;
      prev_crr    <= crr;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int unsigned i, input logic [A-1:0] a);
    cra[i*A +: A] = a;
  endtask

  int unsigned  ord_idx [4] = '{0, 1, 3, 0};
  logic [A-1:0] ord_addr[4] = '{8'h10, 8'h11, 8'h13, 8'h20};
  logic [N-1:0] ord_rdy [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

  initial begin
    reset     = 1'b1;
    crv       = '0;
    cra       = '0;
    mready    = 1'b0;
    mdata_drv = '0;
    mem_auto  = 1'b0;
    #2 reset  = 1'b0;
    tick();
    tick();
    check("rst_mrv", 64'(mrv), 64'd0);
    check("rst_mra", 64'(mra), 64'd0);
    check("rst_crr", 64'(crr), 64'd0);
    check("rst_crd", 64'(crd), 64'd0);
    reset = 1'b1;
    tick();

    // Single request from consumer 2, memory answers on the fourth cycle.
    crv[2] = 1'b1;
    set_addr(2, 8'h1A);
    tick();
    check("single_grant_mrv", 64'(mrv), 64'd1);
    check("single_grant_mra", 64'(mra), 64'h1A);
    check("single_grant_crr", 64'(crr), 64'd0);
    for (int w = 0; w < 3; w++) begin
      tick();
      check("single_wait_mrv", 64'(mrv), 64'd1);
      check("single_wait_mra", 64'(mra), 64'h1A);
      check("single_wait_crr", 64'(crr), 64'd0);
    end
    mready    = 1'b1;
    mdata_drv = 16'hBEEF;
    tick();
    mready = 1'b0;
    check("single_crr", 64'(crr), 64'b0100);
    check("single_data", 64'(crd[2*D +: D]), 64'hBEEF);
    check("single_mrv_drop", 64'(mrv), 64'd0);
    crv[2] = 1'b0;
    tick();
    check("single_crr_pulse", 64'(crr), 64'd0);
    tick();
    check("single_crd_all", 64'(crd), 64'h0000_BEEF_0000_0000);

    // Reset clears data and re-arms the round-robin pointer.
    reset = 1'b0;
    #1;
    check("rst2_crd", 64'(crd), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Contention: 0,1,3 together; 0 re-requests while 1 is served, so it follows 3.
    mem_auto = 1'b1;
    mready   = 1'b1;
    crv      = 4'b1011;
    set_addr(0, 8'h10);
    set_addr(1, 8'h11);
    set_addr(3, 8'h13);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cont_grant_mrv", 64'(mrv), 64'd1);
      check("cont_grant_mra", 64'(mra), 64'(ord_addr[k]));
      tick();
      check("cont_crr", 64'(crr), 64'(ord_rdy[k]));
      check("cont_data", 64'(crd[ord_idx[k]*D +: D]), 64'({8'hC0, ord_addr[k]}));
      check("cont_mrv_drop", 64'(mrv), 64'd0);
      crv[ord_idx[k]] = 1'b0;
      if (k == 1) begin
        crv[0] = 1'b1;
        set_addr(0, 8'h20);
      end
      tick();
      check("cont_crr_pulse", 64'(crr), 64'd0);
      tick();
    end
    check("cont_crd_all", 64'(crd), 64'hC013_0000_C011_C020);

    // Stale hold: consumer 1 keeps valid after its pulse; consumer 2 waits meanwhile.
    crv[1] = 1'b1;
    set_addr(1, 8'h55);
    tick();
    check("stale_grant_mra", 64'(mra), 64'h55);
    tick();
    check("stale_crr", 64'(crr), 64'b0010);
    check("stale_data", 64'(crd[1*D +: D]), 64'hC055);
    crv[2] = 1'b1;
    set_addr(2, 8'h66);
    for (int h = 0; h < 4; h++) begin
      tick();
      check("stale_hold_mrv", 64'(mrv), 64'd0);
      check("stale_hold_crr", 64'(crr), 64'd0);
    end
    crv[1] = 1'b0;
    tick();
    check("stale_release_mrv", 64'(mrv), 64'd0);
    tick();
    check("stale_next_mrv", 64'(mrv), 64'd1);
    check("stale_next_mra", 64'(mra), 64'h66);
    mready = 1'b0;

    // Reset while consumer 2's request is stalled in ISSUE.
    tick();
    check("midrst_pre_mrv", 64'(mrv), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_mrv", 64'(mrv), 64'd0);
    check("midrst_mra", 64'(mra), 64'd0);
    check("midrst_crd", 64'(crd), 64'd0);
    crv = 4'b0101;
    set_addr(0, 8'h77);
    tick();
    check("midrst_crr", 64'(crr), 64'd0);
    reset  = 1'b1;
    mready = 1'b1;
    tick();
    check("midrst_grant_mra", 64'(mra), 64'h77);
    check("midrst_grant_crr", 64'(crr), 64'd0);
    tick();
    check("midrst_crr0", 64'(crr), 64'b0001);
    check("midrst_crd_all", 64'(crd), 64'h0000_0000_0000_C077);
    crv = '0;
    tick();
    tick();

    // Spurious memory ready in IDLE must be ignored.
    mem_auto  = 1'b0;
    mdata_drv = 16'hDEAD;
    mready    = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("spur_mrv", 64'(mrv), 64'd0);
      check("spur_mra", 64'(mra), 64'h77);
      check("spur_crr", 64'(crr), 64'd0);
      check("spur_crd", 64'(crd), 64'h0000_0000_0000_C077);
    end
    mready = 1'b0;
    tick();

    check("proto_addr_stable", 64'(addr_viol), 64'd0);
    check("proto_ready_onehot", 64'(onehot_viol), 64'd0);
    check("proto_ready_consec", 64'(consec_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
